match_req_arbiter: RTL and testbench
====================================

# match_req_arbiter

Shares one match unit between `PE_NUM` job PEs. Each PE's match request and response ports attach upstream; one match unit attaches downstream. Requests are granted round-robin, and each grant is locked until the match unit accepts it. The issuing PE index is recorded in an in-order ID FIFO so that each in-order match response returns to the PE that made the request.

## Interface
Parameters:
- `PE_NUM`, 4: number of job PEs; a power of two, at least 2.
- `MAX_OUTSTANDING`, 8: depth of the ID FIFO, i.e. the maximum number of requests in flight; a power of two.
- `ADDR_WIDTH`, `LAZY_MATCH_LEN`, `MATCH_LEN_WIDTH`: taken from `parameters.vh`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `pe_req_valid` in `PE_NUM`: request valid, one bit per PE.
- `pe_req_head_addr` in `PE_NUM*ADDR_WIDTH`: request head address, one slice per PE (slice i belongs to PE i).
- `pe_req_history_addr` in `PE_NUM*ADDR_WIDTH`: request history address, one slice per PE.
- `pe_req_tag` in `PE_NUM*LAZY_MATCH_LEN`: request tag, one slice per PE.
- `pe_req_ready` out `PE_NUM`: request ready, one bit per PE.
- `pe_resp_valid` out `PE_NUM`: response valid, one bit per PE.
- `pe_resp_len` out `MATCH_LEN_WIDTH`: response length, broadcast to all PEs.
- `pe_resp_tag` out `LAZY_MATCH_LEN`: response tag, broadcast to all PEs.
- `pe_resp_ready` in `PE_NUM`: response ready, one bit per PE.
- `m_req_valid` out 1: request valid to the match unit.
- `m_req_head_addr` out `ADDR_WIDTH`: head address to the match unit.
- `m_req_history_addr` out `ADDR_WIDTH`: history address to the match unit.
- `m_req_tag` out `LAZY_MATCH_LEN`: tag to the match unit.
- `m_req_ready` in 1: match unit accepts the request.
- `m_resp_valid` in 1: response valid from the match unit.
- `m_resp_len` in `MATCH_LEN_WIDTH`: response length from the match unit.
- `m_resp_tag` in `LAZY_MATCH_LEN`: response tag from the match unit.
- `m_resp_ready` out 1: arbiter accepts the response.

## Operation
Arbitration:
- `rr_ptr_reg` (`log2(PE_NUM)` bits) marks the highest-priority PE.
- Selection: the first asserted bit of `pe_req_valid`, searching from `rr_ptr_reg` upward with wrap-around.
- Grant lock:
  - When `m_req_valid` is high and `m_req_ready` is low, set `lock_reg` and record `lock_id_reg`.
  - While `lock_reg` is set, the selection is forced to `lock_id_reg`, so the downstream payload stays stable.
  - `lock_reg` clears on the handshake.
- Issue gating: `m_req_valid = |pe_req_valid && !fifo_full`.
  - The downstream payload is a mux of the selected PE's slices.
  - `pe_req_ready[i] = (i == sel) && m_req_ready && !fifo_full`.
- On the downstream request handshake:
  - Push `sel` into the ID FIFO.
  - Set `rr_ptr_reg <= sel + 1`, wrapping modulo `PE_NUM`.

Response routing:
- The match unit returns responses in issue order; FIFO head `hid` names the destination PE.
- `pe_resp_valid[i] = m_resp_valid && !fifo_empty && (i == hid)`.
- `pe_resp_len` and `pe_resp_tag` pass straight through from `m_resp_len` and `m_resp_tag`.
- `m_resp_ready = fifo_empty ? 1 : pe_resp_ready[hid]`.
- The FIFO pops on a response handshake when it is not empty.
- A response that arrives while the FIFO is empty is a protocol error: it is accepted and dropped, and no PE sees it.

Boundary conditions:
- FIFO full: no issue in that cycle, even if a pop happens in the same cycle; the next cycle proceeds normally.
- Push and pop in the same cycle when neither full nor empty: the count is unchanged.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`; the count register is `log2(MAX_OUTSTANDING)+1` bits wide.
- A locked PE that drops its valid: illegal upstream. The lock is held and the PE's slices keep driving the downstream bus.

Reset: on `rst`:
- `rr_ptr_reg=0`, `lock_reg=0`, `lock_id_reg=0`.
- The FIFO is empty.
- Outputs in the reset cycle: `m_req_valid=0`, `pe_req_ready=0`, `pe_resp_valid=0`, `m_resp_ready=1`.
- Reset mid-operation discards all in-flight IDs. The match unit must be reset in the same cycle.

## Timing
- Request path: zero-cycle, combinational from `pe_req_*` to `m_req_*`.
- Response path: zero-cycle, combinational from `m_resp_*` to `pe_resp_*`.
- State updates on the rising edge of `clk`: round-robin pointer, lock, and FIFO.
- Throughput: one request and one response per cycle.
- Fairness: a PE holding valid is granted within `PE_NUM` downstream handshakes.

## Configuration
- `MATCH_ARB_PERF_CNT_EN` defined:
  - Adds output `perf_grant_cnt` (`PE_NUM*32`): per-PE handshake count, wrapping.
  - Adds output `perf_full_stall_cnt` (32): counts cycles with `|pe_req_valid && fifo_full`.
  - Adds output `perf_orphan_resp_cnt` (16): counts dropped responses.
  - All counters are 0 on reset.
- `MATCH_ARB_PERF_CNT_EN` undefined: the counters and ports are absent, and all other behaviour is identical.

## Structure
- `parameters.vh` gains two constants:
  - `MATCH_ARB_PE_NUM`, with `MATCH_ARB_PE_NUM_LOG2`.
  - `MATCH_ARB_MAX_OUTSTANDING`, with `MATCH_ARB_MAX_OUTSTANDING_LOG2`.
- Slice access uses `VEC_SLICE` from `util.vh`.
- One sub-module, `match_arb_id_fifo`:
  - Synchronous FIFO with parameters depth and width.
  - Ports: push, pop, head, full, empty.
- The round-robin select stays inline.

## Test plan
- Reset check: assert `rst` for 2 cycles with all PEs requesting. Response: `m_req_valid=0`, `m_resp_ready=1`. First grant after release goes to PE0.
- Fairness: all 4 PEs hold valid, `m_req_ready=1`. Response: grants are 0,1,2,3,0,1,2,3. Tags and addresses match each PE's slices.
- Lock: PE2 requests with `m_req_ready=0` for 3 cycles, then PE0 raises valid. Response: the downstream payload stays PE2's; PE2 is accepted when ready rises; PE0 is granted next.
- Outstanding limit and routing: issue 8 requests (PE1,3,1,…) with no responses. Response: the 9th request is blocked. Then return 8 in-order responses with len=5..12. Response: each goes to its issuing PE with the correct len and tag.
- Response backpressure: the head PE holds `pe_resp_ready=0`. Response: `m_resp_ready=0` and the FIFO is held. Then raise a simultaneous push and pop at a non-full, non-empty count. Response: the count is unchanged.
- Orphan response: `m_resp_valid=1` with the FIFO empty. Response: accepted, all `pe_resp_valid=0`; with the macro defined, `perf_orphan_resp_cnt` becomes 1.

Source files
------------

// File: rtl/match_req_arbiter_pkg.sv
// Shared widths, build constants and request payload type for the match request arbiter.
package match_req_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH                    = 16;
  localparam int unsigned LAZY_MATCH_LEN                = 4;
  localparam int unsigned MATCH_LEN_WIDTH               = 6;
  localparam int unsigned MATCH_ARB_PE_NUM              = 4;
  localparam int unsigned MATCH_ARB_PE_NUM_LOG2         = 2;
  localparam int unsigned MATCH_ARB_MAX_OUTSTANDING     = 8;
  localparam int unsigned MATCH_ARB_MAX_OUTSTANDING_LOG2 = 3;
  localparam int unsigned PERF_CNT_WIDTH                = 32;
  localparam int unsigned ORPHAN_CNT_WIDTH              = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [ADDR_WIDTH-1:0]     history_addr;
    logic [LAZY_MATCH_LEN-1:0] tag;
  } match_req_t;

endpackage

// File: rtl/match_arb_id_fifo.sv
// In-order FIFO of issuing PE indices; one push and one pop per cycle.
module match_arb_id_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/match_req_arbiter.sv
// Round-robin share of one match unit among PE_NUM PEs with in-order response routing.
// Optional performance counters when MATCH_ARB_PERF_CNT_EN is defined.
module match_req_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int unsigned PE_NUM          = MATCH_ARB_PE_NUM,
  parameter int unsigned MAX_OUTSTANDING = MATCH_ARB_MAX_OUTSTANDING
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PE_NUM-1:0]                 pe_req_valid,
  input  logic [PE_NUM*ADDR_WIDTH-1:0]      pe_req_head_addr,
  input  logic [PE_NUM*ADDR_WIDTH-1:0]      pe_req_history_addr,
  input  logic [PE_NUM*LAZY_MATCH_LEN-1:0]  pe_req_tag,
  output logic [PE_NUM-1:0]                 pe_req_ready,
  output logic [PE_NUM-1:0]                 pe_resp_valid,
  output logic [MATCH_LEN_WIDTH-1:0]        pe_resp_len,
  output logic [LAZY_MATCH_LEN-1:0]         pe_resp_tag,
  input  logic [PE_NUM-1:0]                 pe_resp_ready,
  output logic                              m_req_valid,
  output logic [ADDR_WIDTH-1:0]             m_req_head_addr,
  output logic [ADDR_WIDTH-1:0]             m_req_history_addr,
  output logic [LAZY_MATCH_LEN-1:0]         m_req_tag,
  input  logic                              m_req_ready,
  input  logic                              m_resp_valid,
  input  logic [MATCH_LEN_WIDTH-1:0]        m_resp_len,
  input  logic [LAZY_MATCH_LEN-1:0]         m_resp_tag,
  output logic                              m_resp_ready
`ifdef MATCH_ARB_PERF_CNT_EN
  ,
  output logic [PE_NUM*PERF_CNT_WIDTH-1:0]  perf_grant_cnt,
  output logic [PERF_CNT_WIDTH-1:0]         perf_full_stall_cnt,
  output logic [ORPHAN_CNT_WIDTH-1:0]       perf_orphan_resp_cnt
`endif
);

  localparam int unsigned PW = $clog2(PE_NUM);

  logic [PW-1:0] rr_ptr_reg;
  logic [PW-1:0] lock_id_reg;
  logic          lock_reg;
  logic [PW-1:0] sel;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] hid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_hs;
  logic          resp_pop;
  match_req_t    pe_req [PE_NUM];
  match_req_t    m_req;

  for (genvar i = 0; i < PE_NUM; i++) begin : g_slice
    assign pe_req[i] = {pe_req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                        pe_req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                        pe_req_tag[i*LAZY_MATCH_LEN +: LAZY_MATCH_LEN]};
  end

  // First requester at or after rr_ptr_reg; a pending lock overrides the search.
  always_comb begin
    sel      = rr_ptr_reg;
    scan_idx = rr_ptr_reg;
    if (lock_reg) begin
      sel = lock_id_reg;
    end else begin
      for (int k = int'(PE_NUM) - 1; k >= 0; k--) begin
        scan_idx = rr_ptr_reg + PW'(k);
        if (pe_req_valid[scan_idx]) sel = scan_idx;
      end
    end
  end

  assign m_req              = pe_req[sel];
  assign m_req_head_addr    = m_req.head_addr;
  assign m_req_history_addr = m_req.history_addr;
  assign m_req_tag          = m_req.tag;
  assign m_req_valid        = !rst && (|pe_req_valid) && !fifo_full;
  assign req_hs             = m_req_valid && m_req_ready;

  always_comb begin
    pe_req_ready = '0;
    if (!rst && m_req_ready && !fifo_full) pe_req_ready[sel] = 1'b1;
  end

  // Responses follow the FIFO head; with nothing in flight they are sunk.
  always_comb begin
    pe_resp_valid = '0;
    if (!rst && m_resp_valid && !fifo_empty) pe_resp_valid[hid] = 1'b1;
  end

  assign m_resp_ready = (rst || fifo_empty) ? 1'b1 : pe_resp_ready[hid];
  assign pe_resp_len  = m_resp_len;
  assign pe_resp_tag  = m_resp_tag;
  assign resp_pop     = !rst && m_resp_valid && m_resp_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
    end else if (req_hs) begin
      rr_ptr_reg <= sel + PW'(1);
      lock_reg   <= 1'b0;
    end else if (m_req_valid) begin
      lock_reg    <= 1'b1;
      lock_id_reg <= sel;
    end
  end

  match_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PW)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_hs),
    .push_data (sel),
    .pop       (resp_pop),
    .head      (hid),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MATCH_ARB_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] grant_cnt [PE_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PE_NUM); i++) grant_cnt[i] <= '0;
      perf_full_stall_cnt  <= '0;
      perf_orphan_resp_cnt <= '0;
    end else begin
      if (req_hs) grant_cnt[sel] <= grant_cnt[sel] + PERF_CNT_WIDTH'(1);
      if ((|pe_req_valid) && fifo_full)
        perf_full_stall_cnt <= perf_full_stall_cnt + PERF_CNT_WIDTH'(1);
      if (m_resp_valid && fifo_empty)
        perf_orphan_resp_cnt <= perf_orphan_resp_cnt + ORPHAN_CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_perf
    assign perf_grant_cnt[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_match_req_arbiter.sv
// Scenario bench for match_req_arbiter; issued PE indices are queued and checked against routed responses.
module tb_match_req_arbiter;
  import match_req_arbiter_pkg::*;

  localparam int unsigned NPE = 4;
  localparam int unsigned PLW = 2 * ADDR_WIDTH + LAZY_MATCH_LEN;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NPE-1:0]                pe_req_valid;
  logic [NPE*ADDR_WIDTH-1:0]     pe_req_head_addr;
  logic [NPE*ADDR_WIDTH-1:0]     pe_req_history_addr;
  logic [NPE*LAZY_MATCH_LEN-1:0] pe_req_tag;
  logic [NPE-1:0]                pe_req_ready;
  logic [NPE-1:0]                pe_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0]    pe_resp_len;
  logic [LAZY_MATCH_LEN-1:0]     pe_resp_tag;
  logic [NPE-1:0]                pe_resp_ready;
  logic                          m_req_valid;
  logic [ADDR_WIDTH-1:0]         m_req_head_addr;
  logic [ADDR_WIDTH-1:0]         m_req_history_addr;
  logic [LAZY_MATCH_LEN-1:0]     m_req_tag;
  logic                          m_req_ready;
  logic                          m_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0]    m_resp_len;
  logic [LAZY_MATCH_LEN-1:0]     m_resp_tag;
  logic                          m_resp_ready;
`ifdef MATCH_ARB_PERF_CNT_EN
  logic [NPE*PERF_CNT_WIDTH-1:0] perf_grant_cnt;
  logic [PERF_CNT_WIDTH-1:0]     perf_full_stall_cnt;
  logic [ORPHAN_CNT_WIDTH-1:0]   perf_orphan_resp_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  match_req_arbiter #(
    .PE_NUM          (NPE),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pe_req_valid        (pe_req_valid),
    .pe_req_head_addr    (pe_req_head_addr),
    .pe_req_history_addr (pe_req_history_addr),
    .pe_req_tag          (pe_req_tag),
    .pe_req_ready        (pe_req_ready),
    .pe_resp_valid       (pe_resp_valid),
    .pe_resp_len         (pe_resp_len),
    .pe_resp_tag         (pe_resp_tag),
    .pe_resp_ready       (pe_resp_ready),
    .m_req_valid         (m_req_valid),
    .m_req_head_addr     (m_req_head_addr),
    .m_req_history_addr  (m_req_history_addr),
    .m_req_tag           (m_req_tag),
    .m_req_ready         (m_req_ready),
    .m_resp_valid        (m_resp_valid),
    .m_resp_len          (m_resp_len),
    .m_resp_tag          (m_resp_tag),
    .m_resp_ready        (m_resp_ready)
`ifdef MATCH_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt       (perf_grant_cnt),
    .perf_full_stall_cnt  (perf_full_stall_cnt),
    .perf_orphan_resp_cnt (perf_orphan_resp_cnt)
`endif
  );

  function automatic logic [ADDR_WIDTH-1:0] head_of(input int pe);
    return ADDR_WIDTH'(32'h1100 * (pe + 1));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] hist_of(input int pe);
    return ADDR_WIDTH'(32'hA005 + 32'h0110 * pe);
  endfunction

  function automatic logic [LAZY_MATCH_LEN-1:0] tag_of(input int pe);
    return LAZY_MATCH_LEN'(pe * 5 + 3);
  endfunction

  function automatic logic [PLW-1:0] exp_payload(input int pe);
    return {head_of(pe), hist_of(pe), tag_of(pe)};
  endfunction

  function automatic logic [NPE-1:0] onehot(input int pe);
    return NPE'(1 << pe);
  endfunction

  // Sample point: 1 ns after the rising edge; inputs are changed here too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pe_req_valid  = '0;
    m_req_ready   = 1'b0;
    m_resp_valid  = 1'b0;
    m_resp_len    = '0;
    m_resp_tag    = '0;
    pe_resp_ready = '1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pe_req_valid = '1;
    m_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({m_req_valid, m_resp_ready, pe_req_ready, pe_resp_valid} !== {1'b0, 1'b1, 4'h0, 4'h0}) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got req_v=%b resp_rdy=%b req_rdy=%b resp_v=%b, want 0 1 0000 0000",
                 c, m_req_valid, m_resp_ready, pe_req_ready, pe_resp_valid);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (m_req_valid !== 1'b1 || pe_req_ready !== 4'b0001 || {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(0)) begin
      miscompares++;
      $display("FAIL reset_first_grant: got valid=%b ready=%b payload=%h, want 1 0001 %h",
               m_req_valid, pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag}, exp_payload(0));
    end
    step();
    vectors++;
    if (pe_req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_second_grant: got ready=%b want 0010", pe_req_ready);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    pe_req_valid = '1;
    m_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      vectors++;
      if (m_req_valid !== 1'b1 || pe_req_ready !== onehot(k % 4) ||
          {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(k % 4)) begin
        miscompares++;
        $display("FAIL fairness_grant %0d: got valid=%b ready=%b payload=%h, want 1 %b %h",
                 k, m_req_valid, pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag},
                 onehot(k % 4), exp_payload(k % 4));
      end
      exp_q.push_back(k % 4);
      step();
    end
    #1;
    vectors++;
    if (m_req_valid !== 1'b0 || pe_req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL fairness_full_block: got valid=%b ready=%b, want 0 0000", m_req_valid, pe_req_ready);
    end
  endtask

  task automatic test_lock();
    do_reset();
    pe_req_valid = 4'b0100;
    m_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (m_req_valid !== 1'b1 || pe_req_ready !== 4'b0000 ||
          {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(2)) begin
        miscompares++;
        $display("FAIL lock_hold %0d: got valid=%b ready=%b payload=%h, want 1 0000 %h",
                 c, m_req_valid, pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag}, exp_payload(2));
      end
      step();
    end
    pe_req_valid = 4'b0101;
    m_req_ready = 1'b1;
    #1;
    vectors++;
    if (pe_req_ready !== 4'b0100 || {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(2)) begin
      miscompares++;
      $display("FAIL lock_accept: got ready=%b payload=%h, want 0100 %h",
               pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag}, exp_payload(2));
    end
    step();
    vectors++;
    if (pe_req_ready !== 4'b0001 || {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(0)) begin
      miscompares++;
      $display("FAIL lock_next_grant: got ready=%b payload=%h, want 0001 %h",
               pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag}, exp_payload(0));
    end
    step();
  endtask

  task automatic test_outstanding();
    int pe;
    do_reset();
    m_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pe = (k % 2 == 0) ? 1 : 3;
      pe_req_valid = onehot(pe);
      #1;
      vectors++;
      if (pe_req_ready !== onehot(pe) || {m_req_head_addr, m_req_history_addr, m_req_tag} !== exp_payload(pe)) begin
        miscompares++;
        $display("FAIL outstanding_issue %0d: got ready=%b payload=%h, want %b %h",
                 k, pe_req_ready, {m_req_head_addr, m_req_history_addr, m_req_tag}, onehot(pe), exp_payload(pe));
      end
      exp_q.push_back(pe);
      step();
    end
    pe_req_valid = 4'b0010;
    #1;
    vectors++;
    if (m_req_valid !== 1'b0 || pe_req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL ninth_blocked: got valid=%b ready=%b, want 0 0000", m_req_valid, pe_req_ready);
    end
    step();
    pe_resp_ready = '1;
    for (int k = 0; k < 9; k++) begin
      pe = exp_q.pop_front();
      pe_req_valid = (k < 2) ? 4'b0010 : 4'b0000;
      m_resp_valid = 1'b1;
      m_resp_len = MATCH_LEN_WIDTH'(5 + k);
      m_resp_tag = tag_of(pe);
      #1;
      vectors++;
      if (pe_resp_valid !== onehot(pe) || pe_resp_len !== MATCH_LEN_WIDTH'(5 + k) ||
          pe_resp_tag !== tag_of(pe) || m_resp_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL route_resp %0d: got valid=%b len=%0d tag=%h rdy=%b, want %b %0d %h 1",
                 k, pe_resp_valid, pe_resp_len, pe_resp_tag, m_resp_ready, onehot(pe), 5 + k, tag_of(pe));
      end
      if (k == 0) begin
        vectors++;
        if (m_req_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL full_pop_no_issue: got valid=%b want 0", m_req_valid);
        end
      end else if (k == 1) begin
        vectors++;
        if (m_req_valid !== 1'b1 || pe_req_ready !== 4'b0010) begin
          miscompares++;
          $display("FAIL after_full_issue: got valid=%b ready=%b, want 1 0010", m_req_valid, pe_req_ready);
        end
        exp_q.push_back(1);
      end
      step();
    end
    m_resp_valid = 1'b0;
    pe_req_valid = '0;
  endtask

  task automatic test_backpressure();
    int pe;
    do_reset();
    m_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pe_req_valid = onehot(k);
      #1;
      vectors++;
      if (pe_req_ready !== onehot(k)) begin
        miscompares++;
        $display("FAIL bp_issue %0d: got ready=%b want %b", k, pe_req_ready, onehot(k));
      end
      exp_q.push_back(k);
      step();
    end
    pe_req_valid = '0;
    m_resp_valid = 1'b1;
    m_resp_len = 6'd7;
    m_resp_tag = tag_of(0);
    pe_resp_ready = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (pe_resp_valid !== 4'b0001 || m_resp_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold %0d: got valid=%b rdy=%b, want 0001 0", c, pe_resp_valid, m_resp_ready);
      end
      step();
    end
    pe_resp_ready = '1;
    pe_req_valid = 4'b1000;
    #1;
    vectors++;
    if (m_req_valid !== 1'b1 || pe_req_ready !== 4'b1000 || pe_resp_valid !== 4'b0001 || m_resp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_pop_same_cycle: got req_v=%b req_rdy=%b resp_v=%b resp_rdy=%b, want 1 1000 0001 1",
               m_req_valid, pe_req_ready, pe_resp_valid, m_resp_ready);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(3);
    step();
    pe_req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      pe = exp_q.pop_front();
      m_resp_tag = tag_of(pe);
      #1;
      vectors++;
      if (pe_resp_valid !== onehot(pe) || pe_resp_tag !== tag_of(pe)) begin
        miscompares++;
        $display("FAIL bp_drain %0d: got valid=%b tag=%h, want %b %h", k, pe_resp_valid, pe_resp_tag, onehot(pe), tag_of(pe));
      end
      step();
    end
    #1;
    vectors++;
    if (pe_resp_valid !== 4'b0000 || m_resp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_count_unchanged: got valid=%b rdy=%b after 3 pops, want 0000 1", pe_resp_valid, m_resp_ready);
    end
    step();
    m_resp_valid = 1'b0;
  endtask

  task automatic test_orphan();
    do_reset();
    m_resp_valid = 1'b1;
    m_resp_len = 6'd9;
    m_resp_tag = 4'h0;
    pe_resp_ready = '0;
    #1;
    vectors++;
    if (pe_resp_valid !== 4'b0000 || m_resp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL orphan_drop: got valid=%b rdy=%b, want 0000 1", pe_resp_valid, m_resp_ready);
    end
    step();
    m_resp_valid = 1'b0;
`ifdef MATCH_ARB_PERF_CNT_EN
    vectors++;
    if (perf_orphan_resp_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL orphan_count: got %0d want 1", perf_orphan_resp_cnt);
    end
`endif
    pe_req_valid = 4'b0100;
    m_req_ready = 1'b1;
    #1;
    vectors++;
    if (pe_req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL orphan_then_issue: got ready=%b want 0100", pe_req_ready);
    end
    step();
    pe_req_valid = '0;
    m_resp_valid = 1'b1;
    m_resp_tag = tag_of(2);
    pe_resp_ready = '1;
    #1;
    vectors++;
    if (pe_resp_valid !== 4'b0100 || pe_resp_tag !== tag_of(2)) begin
      miscompares++;
      $display("FAIL orphan_then_route: got valid=%b tag=%h, want 0100 %h", pe_resp_valid, pe_resp_tag, tag_of(2));
    end
`ifdef MATCH_ARB_PERF_CNT_EN
    vectors++;
    if (perf_grant_cnt[2*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] !== 32'd1) begin
      miscompares++;
      $display("FAIL grant_count_pe2: got %0d want 1", perf_grant_cnt[2*PERF_CNT_WIDTH +: PERF_CNT_WIDTH]);
    end
`endif
    step();
    m_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NPE); i++) begin
      pe_req_head_addr[i*ADDR_WIDTH +: ADDR_WIDTH]        = head_of(i);
      pe_req_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH]     = hist_of(i);
      pe_req_tag[i*LAZY_MATCH_LEN +: LAZY_MATCH_LEN]      = tag_of(i);
    end
    rst           = 1'b1;
    pe_req_valid  = '0;
    m_req_ready   = 1'b0;
    m_resp_valid  = 1'b0;
    m_resp_len    = '0;
    m_resp_tag    = '0;
    pe_resp_ready = '1;
    test_reset();
    test_fairness();
    test_lock();
    test_outstanding();
    test_backpressure();
    test_orphan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
